// File: rtl/virtual_ds2431_pkg.sv
// Shared constants and types for the virtual DS2431 command executors.
package virtual_ds2431_pkg;

    localparam logic [7:0]  CMD_READ_SCRATCHPAD = 8'hAA;
    localparam logic [15:0] CRC16_POLY          = 16'hA001;
    localparam logic [7:0]  SENT_DAT_IDLE       = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT_LO,
        ST_WAIT_HI,
        ST_NEXT,
        ST_DONE
    } rs_state_t;

endpackage

// File: rtl/virtual_ds2431_crc16_byte.sv
// One-byte CRC16 update, x^16+x^15+x^2+1 shifted LSB-first (reflected form).
module virtual_ds2431_crc16_byte
    import virtual_ds2431_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  dat,
    output logic [15:0] crc_out
);

    always_comb begin
        logic [15:0] c;
        logic        fb;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ dat[i];
            c  = c >> 1;
            if (fb) c = c ^ CRC16_POLY;
        end
        crc_out = c;
    end

endmodule

// File: rtl/virtual_ds2431_mem_read_scratchpad.sv
// Read Scratchpad executor: streams TA1, TA2, E/S, scratchpad bytes T..E and
// the inverted CRC16 through the shared byte transport.
module virtual_ds2431_mem_read_scratchpad
    import virtual_ds2431_pkg::*;
#(
    parameter logic [7:0]  CMD_CODE      = CMD_READ_SCRATCHPAD,
    parameter logic [15:0] TRANS_TIMEOUT = 16'd0
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cmdRunTrig,
    input  logic        endCmd,
    input  logic [7:0]  TA1,
    input  logic [7:0]  TA2,
    input  logic [7:0]  ES,
    input  logic [63:0] Scratchpad,
    output logic [7:0]  sentDat,
    output logic        transTrig,
    output logic        nRxTx,
    input  logic        ByteTransDone,
    output logic        cmdDone,
    output logic        cmdFailed,
    output logic        busy
);

    rs_state_t   state, state_next;
    logic [7:0]  ta1_q, ta2_q, es_q;
    logic [63:0] pad_q;
    logic [15:0] crc;
    logic [3:0]  ptr;
    logic [15:0] tmo_cnt, tmo_inc;
    logic        failed_q;

    logic [2:0]  t_off, e_off, span, data_idx;
    logic [3:0]  n_data, data_end, last_ptr;
    logic [7:0]  cur_byte;
    logic        is_crc_byte, timeout_hit, abort;
    logic [15:0] crc_in, crc_out;
    logic [7:0]  crc_dat;

    // Byte layout: ptr 0..2 header, then n_data payload bytes, then two CRC bytes.
    always_comb begin
        t_off       = ta1_q[2:0];
        e_off       = es_q[2:0];
        span        = e_off - t_off;
        n_data      = (e_off >= t_off) ? ({1'b0, span} + 4'd1) : 4'd0;
        data_end    = 4'd3 + n_data;
        last_ptr    = data_end + 4'd1;
        data_idx    = t_off + ptr[2:0] - 3'd3;
        is_crc_byte = (ptr >= data_end);

        cur_byte = SENT_DAT_IDLE;
        if (ptr == 4'd0)
            cur_byte = ta1_q;
        else if (ptr == 4'd1)
            cur_byte = ta2_q;
        else if (ptr == 4'd2)
            cur_byte = es_q;
        else if (ptr < data_end)
            cur_byte = pad_q[{data_idx, 3'b000} +: 8];
        else if (ptr == data_end)
            cur_byte = ~crc[7:0];
        else
            cur_byte = ~crc[15:8];
    end

    // LOAD seeds with the command code from zero; SEND folds in the outgoing byte.
    always_comb begin
        crc_in  = crc;
        crc_dat = cur_byte;
        if (state == ST_LOAD) begin
            crc_in  = 16'h0000;
            crc_dat = CMD_CODE;
        end
    end

    virtual_ds2431_crc16_byte u_crc (
        .crc_in  (crc_in),
        .dat     (crc_dat),
        .crc_out (crc_out)
    );

    assign tmo_inc     = tmo_cnt + 16'd1;
    assign timeout_hit = (TRANS_TIMEOUT != 16'd0)
                       && ((state == ST_WAIT_LO) || (state == ST_WAIT_HI))
                       && (tmo_inc == TRANS_TIMEOUT);

    always_comb begin
        state_next = state;
        abort      = 1'b0;
        case (state)
            ST_IDLE:    if (cmdRunTrig && !endCmd) state_next = ST_LOAD;
            ST_LOAD:    state_next = ST_SEND;
            ST_SEND:    state_next = ST_WAIT_LO;
            ST_WAIT_LO: if (!ByteTransDone) state_next = ST_WAIT_HI;
            ST_WAIT_HI: if (ByteTransDone) state_next = ST_NEXT;
            ST_NEXT:    state_next = (ptr == last_ptr) ? ST_DONE : ST_SEND;
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
        // Abort wins over any transport edge seen in the same cycle.
        if ((state != ST_IDLE) && (endCmd || timeout_hit)) begin
            state_next = ST_IDLE;
            abort      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            ta1_q    <= 8'h00;
            ta2_q    <= 8'h00;
            es_q     <= 8'h00;
            pad_q    <= 64'h0;
            crc      <= 16'h0000;
            ptr      <= 4'd0;
            tmo_cnt  <= 16'd0;
            failed_q <= 1'b0;
        end else begin
            state    <= state_next;
            failed_q <= abort;
            case (state)
                ST_LOAD: begin
                    ta1_q <= TA1;
                    ta2_q <= TA2;
                    es_q  <= ES;
                    pad_q <= Scratchpad;
                    crc   <= crc_out;
                    ptr   <= 4'd0;
                end
                ST_SEND: begin
                    if (!is_crc_byte) crc <= crc_out;
                    tmo_cnt <= 16'd0;
                end
                ST_WAIT_LO, ST_WAIT_HI: tmo_cnt <= tmo_inc;
                ST_NEXT: if (state_next == ST_SEND) ptr <= ptr + 4'd1;
                default: ;
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign nRxTx     = busy;
    assign transTrig = (state == ST_SEND);
    assign cmdDone   = (state == ST_DONE);
    assign cmdFailed = failed_q;
    assign sentDat   = ((state == ST_IDLE) || (state == ST_LOAD)) ? SENT_DAT_IDLE : cur_byte;

endmodule

// File: tb/tb_virtual_ds2431_mem_read_scratchpad.sv
// Directed bench for the Read Scratchpad executor: byte streams, CRC, abort paths.
module tb_virtual_ds2431_mem_read_scratchpad;

    logic        clk, rst;
    logic        cmdRunTrig, endCmd, ByteTransDone;
    logic [7:0]  TA1, TA2, ES, sentDat;
    logic [63:0] Scratchpad;
    logic        transTrig, nRxTx, cmdDone, cmdFailed, busy;

    logic        cmd2, end2, btd2;
    logic [7:0]  ta1_2, ta2_2, es_2, sent2;
    logic [63:0] pad2;
    logic        trig2, nrxtx2, done2, failed2, busy2;

    int checks = 0;
    int errors = 0;

    int trig_cnt, done_cnt, fail_cnt, bytes_done;
    int since_rise, gap_bad, gap_seen;
    bit rise_seen;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    virtual_ds2431_mem_read_scratchpad dut (
        .clk(clk), .rst(rst), .cmdRunTrig(cmdRunTrig), .endCmd(endCmd),
        .TA1(TA1), .TA2(TA2), .ES(ES), .Scratchpad(Scratchpad),
        .sentDat(sentDat), .transTrig(transTrig), .nRxTx(nRxTx),
        .ByteTransDone(ByteTransDone), .cmdDone(cmdDone), .cmdFailed(cmdFailed),
        .busy(busy)
    );

    virtual_ds2431_mem_read_scratchpad #(.TRANS_TIMEOUT(16'd100)) dut_tmo (
        .clk(clk), .rst(rst), .cmdRunTrig(cmd2), .endCmd(end2),
        .TA1(ta1_2), .TA2(ta2_2), .ES(es_2), .Scratchpad(pad2),
        .sentDat(sent2), .transTrig(trig2), .nRxTx(nrxtx2),
        .ByteTransDone(btd2), .cmdDone(done2), .cmdFailed(failed2),
        .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte transport for the main instance: low 1500 ns after each request.
    initial begin
        ByteTransDone = 1'b1;
        forever begin
            @(negedge clk);
            if (transTrig === 1'b1) begin
                #1 ByteTransDone = 1'b0;
                #1500 ByteTransDone = 1'b1;
                bytes_done++;
                rise_seen  = 1'b1;
                since_rise = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            since_rise++;
            if (transTrig === 1'b1) begin
                got_q.push_back(sentDat);
                trig_cnt++;
                if (rise_seen) begin
                    gap_seen++;
                    if (since_rise != 2) gap_bad++;
                    rise_seen = 1'b0;
                end
            end
            if (cmdDone === 1'b1) done_cnt++;
            if (cmdFailed === 1'b1) fail_cnt++;
        end
    end

    function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return r;
    endfunction

    task automatic make_exp(input logic [7:0] ta1, input logic [7:0] ta2,
                            input logic [7:0] es, input logic [63:0] pad);
        logic [15:0] c;
        logic [7:0]  b;
        int t, e;
        exp_q.delete();
        c = crc_model(16'h0000, 8'hAA);
        exp_q.push_back(ta1); c = crc_model(c, ta1);
        exp_q.push_back(ta2); c = crc_model(c, ta2);
        exp_q.push_back(es);  c = crc_model(c, es);
        t = int'(ta1[2:0]);
        e = int'(es[2:0]);
        for (int i = t; i <= e; i++) begin
            b = pad[8*i +: 8];
            exp_q.push_back(b);
            c = crc_model(c, b);
        end
        exp_q.push_back(~c[7:0]);
        exp_q.push_back(~c[15:8]);
    endtask

    task automatic clear_mon;
        got_q.delete();
        trig_cnt = 0; done_cnt = 0; fail_cnt = 0; bytes_done = 0;
        gap_bad = 0; gap_seen = 0; rise_seen = 1'b0;
    endtask

    task automatic run_cmd(input string name, input logic [7:0] ta1, input logic [7:0] ta2,
                           input logic [7:0] es, input logic [63:0] pad, input bit poke);
        make_exp(ta1, ta2, es, pad);
        clear_mon();
        TA1 = ta1; TA2 = ta2; ES = es; Scratchpad = pad;
        @(negedge clk) cmdRunTrig = 1'b1;
        @(negedge clk) cmdRunTrig = 1'b0;
        checks++;
        if (transTrig !== 1'b0) begin
            errors++; $display("FAIL %s early_trig: got %b expected 0", name, transTrig);
        end
        @(negedge clk);
        checks++;
        if (transTrig !== 1'b1) begin
            errors++; $display("FAIL %s latency: transTrig got %b expected 1", name, transTrig);
        end
        // Inputs are snapshotted; scrambling them now must not disturb the stream.
        TA1 = 8'h5F; TA2 = 8'hC3; ES = 8'h01; Scratchpad = 64'hDEADBEEF_0BADF00D;
        for (int cyc = 0; cyc < 6000 && done_cnt == 0 && fail_cnt == 0; cyc++) begin
            @(negedge clk);
            cmdRunTrig = (poke && cyc == 300);
        end
        cmdRunTrig = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (trig_cnt != exp_q.size()) begin
            errors++; $display("FAIL %s trig_count: got %0d expected %0d", name, trig_cnt, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s byte%0d: got %02h expected %02h", name, i,
                         (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
        checks++;
        if (done_cnt != 1 || fail_cnt != 0) begin
            errors++; $display("FAIL %s done_pulses: got done=%0d failed=%0d expected 1/0", name, done_cnt, fail_cnt);
        end
        checks++;
        if (gap_bad != 0 || gap_seen != exp_q.size() - 1) begin
            errors++; $display("FAIL %s rise_to_trig: bad=%0d seen=%0d expected 0/%0d", name, gap_bad, gap_seen, exp_q.size() - 1);
        end
        checks++;
        if (busy !== 1'b0 || nRxTx !== 1'b0 || sentDat !== 8'hFF) begin
            errors++; $display("FAIL %s idle_after: busy=%b nRxTx=%b sentDat=%02h expected 0/0/ff", name, busy, nRxTx, sentDat);
        end
    endtask

    task automatic test_reset;
        checks++;
        if ({sentDat, transTrig, nRxTx, cmdDone, cmdFailed, busy} !== {8'hFF, 5'b00000}) begin
            errors++; $display("FAIL reset_main: got %02h %b%b%b%b%b expected ff 00000",
                               sentDat, transTrig, nRxTx, cmdDone, cmdFailed, busy);
        end
        checks++;
        if ({sent2, trig2, nrxtx2, done2, failed2, busy2} !== {8'hFF, 5'b00000}) begin
            errors++; $display("FAIL reset_tmo: got %02h %b%b%b%b%b expected ff 00000",
                               sent2, trig2, nrxtx2, done2, failed2, busy2);
        end
    endtask

    task automatic test_full_span;
        run_cmd("full_span", 8'h20, 8'h00, 8'h07, 64'ha005160ba6aae756, 1'b0);
    endtask

    task automatic test_busy_retrigger;
        run_cmd("busy_retrig", 8'h28, 8'h00, 8'h07, 64'h2174083a9497987b, 1'b1);
    endtask

    task automatic test_partial;
        run_cmd("partial", 8'h03, 8'h00, 8'h05, 64'h555555555555afff, 1'b0);
        checks++;
        if (exp_q.size() != 8 || got_q.size() != 8) begin
            errors++; $display("FAIL partial_len: got %0d expected 8", got_q.size());
        end
    endtask

    task automatic test_empty_range;
        run_cmd("empty_range", 8'h06, 8'h00, 8'h02, 64'h0123456789abcdef, 1'b0);
    endtask

    task automatic test_end_cmd;
        clear_mon();
        TA1 = 8'h00; TA2 = 8'h00; ES = 8'h07; Scratchpad = 64'h1122334455667788;
        @(negedge clk) cmdRunTrig = 1'b1;
        @(negedge clk) cmdRunTrig = 1'b0;
        for (int cyc = 0; cyc < 3000 && bytes_done < 4; cyc++) @(negedge clk);
        checks++;
        if (bytes_done != 4) begin
            errors++; $display("FAIL endcmd_reach4: got %0d bytes expected 4", bytes_done);
        end
        endCmd = 1'b1;
        @(negedge clk) endCmd = 1'b0;
        checks++;
        if (cmdFailed !== 1'b1 || busy !== 1'b0 || transTrig !== 1'b0) begin
            errors++; $display("FAIL endcmd_abort: failed=%b busy=%b trig=%b expected 1/0/0", cmdFailed, busy, transTrig);
        end
        repeat (300) @(negedge clk);
        checks++;
        if (trig_cnt != 4 || done_cnt != 0 || fail_cnt != 1) begin
            errors++; $display("FAIL endcmd_after: trig=%0d done=%0d failed=%0d expected 4/0/1", trig_cnt, done_cnt, fail_cnt);
        end
    endtask

    task automatic test_rst_mid;
        clear_mon();
        TA1 = 8'h00; TA2 = 8'h01; ES = 8'h07; Scratchpad = 64'h8877665544332211;
        @(negedge clk) cmdRunTrig = 1'b1;
        @(negedge clk) cmdRunTrig = 1'b0;
        for (int cyc = 0; cyc < 3000 && bytes_done < 2; cyc++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        checks++;
        if ({sentDat, transTrig, nRxTx, cmdDone, cmdFailed, busy} !== {8'hFF, 5'b00000}) begin
            errors++; $display("FAIL rst_mid: got %02h %b%b%b%b%b expected ff 00000",
                               sentDat, transTrig, nRxTx, cmdDone, cmdFailed, busy);
        end
        repeat (300) @(negedge clk);
        checks++;
        if (done_cnt != 0 || fail_cnt != 0 || trig_cnt != 2) begin
            errors++; $display("FAIL rst_mid_after: trig=%0d done=%0d failed=%0d expected 2/0/0", trig_cnt, done_cnt, fail_cnt);
        end
    endtask

    task automatic test_timeout;
        int n, lowcnt;
        bit seen, fin;
        logic [7:0] got2[$];
        ta1_2 = 8'h01; ta2_2 = 8'h00; es_2 = 8'h03; pad2 = 64'h0f0e0d0c0b0a0908;
        btd2 = 1'b1;
        @(negedge clk) cmd2 = 1'b1;
        @(negedge clk) cmd2 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (trig2 === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL tmo_first_trig: got none expected a pulse");
        end
        btd2 = 1'b0;
        n = 0;
        while (failed2 !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n < 100 || n > 101) begin
            errors++; $display("FAIL tmo_delay: got %0d clocks expected 100..101", n);
        end
        checks++;
        if (busy2 !== 1'b0 || done2 !== 1'b0) begin
            errors++; $display("FAIL tmo_idle: busy=%b done=%b expected 0/0", busy2, done2);
        end
        // Restart with a responsive transport; CRC must be reseeded from scratch.
        btd2 = 1'b1;
        repeat (3) @(negedge clk);
        ta1_2 = 8'h03; ta2_2 = 8'h00; es_2 = 8'h05; pad2 = 64'h555555555555afff;
        make_exp(ta1_2, ta2_2, es_2, pad2);
        @(negedge clk) cmd2 = 1'b1;
        @(negedge clk) cmd2 = 1'b0;
        lowcnt = 0;
        fin = 1'b0;
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            @(negedge clk);
            if (trig2 === 1'b1) begin
                got2.push_back(sent2);
                btd2 = 1'b0;
                lowcnt = 10;
            end else if (lowcnt > 0) begin
                lowcnt--;
                if (lowcnt == 0) btd2 = 1'b1;
            end
            if (done2 === 1'b1) fin = 1'b1;
            checks++;
            if (failed2 !== 1'b0) begin
                errors++; $display("FAIL tmo_restart_abort: cmdFailed got %b expected 0", failed2);
            end
        end
        checks++;
        if (!fin || got2.size() != exp_q.size()) begin
            errors++; $display("FAIL tmo_restart_len: done=%b bytes=%0d expected 1/%0d", fin, got2.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got2.size() || got2[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL tmo_restart byte%0d: got %02h expected %02h", i,
                         (i < got2.size()) ? got2[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; cmdRunTrig = 1'b0; endCmd = 1'b0;
        TA1 = 8'h00; TA2 = 8'h00; ES = 8'h00; Scratchpad = 64'h0;
        cmd2 = 1'b0; end2 = 1'b0; btd2 = 1'b1;
        ta1_2 = 8'h00; ta2_2 = 8'h00; es_2 = 8'h00; pad2 = 64'h0;
        clear_mon();
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        test_full_span();
        test_busy_retrigger();
        test_partial();
        test_empty_range();
        test_end_cmd();
        test_rst_mid();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
